apb_slave_regfile: RTL

- Synthesizable APB responder that answers transfers issued by the team's APB master agent/driver on APB_If.
- Holds a small bank of 16-bit registers with a read-only ID register at index 0.
- Programmable wait states, error response on illegal accesses, and abort on protocol violations.
- Instantiated as the DUT behind the slave side of APB_If in agent-level and environment-level benches.

---
 rtl/apb_slave_regfile.sv | 122 ++++++++++++
 1 files changed

// File: rtl/apb_slave_regfile.sv
// APB responder over a bank of 16-bit registers; register 0 is a read-only ID.
// Completes in 2+WAIT_STATES cycles; bad addresses and writes to reg 0 complete with perror.
module apb_slave_regfile #(
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] ID_VALUE    = 16'hA5B0
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [15:0] paddr,
    input  logic [15:0] pwdata,
    output logic [15:0] prdata,
    output logic        pready,
    output logic        perror
);

    localparam int          AW    = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
    localparam logic [16:0] LIMIT = 17'(NUM_REGS);
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [15:0] cap_addr;
    logic [15:0] cap_wdata;
    logic        cap_write;
    logic [15:0] regs [NUM_REGS];

    logic        setup_err;
    logic [15:0] setup_rdata;
    logic        cap_err;
    logic [15:0] cap_rdata;
    logic [AW-1:0] setup_idx;
    logic [AW-1:0] cap_idx;

    assign setup_idx = paddr[AW-1:0];
    assign cap_idx   = cap_addr[AW-1:0];

    // With zero wait states the response is formed from the live setup-phase bus,
    // which at that edge is identical to what gets captured.
    always_comb begin
        setup_err   = ({1'b0, paddr} >= LIMIT) || (pwrite && (paddr == 16'd0));
        setup_rdata = 16'd0;
        if (!setup_err && !pwrite) begin
            setup_rdata = regs[setup_idx];
        end
    end

    always_comb begin
        cap_err   = ({1'b0, cap_addr} >= LIMIT) || (cap_write && (cap_addr == 16'd0));
        cap_rdata = 16'd0;
        if (!cap_err && !cap_write) begin
            cap_rdata = regs[cap_idx];
        end
    end

    always_ff @(posedge pclk) begin
        if (!preset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            pready    <= 1'b0;
            perror    <= 1'b0;
            prdata    <= 16'd0;
            cap_addr  <= 16'd0;
            cap_wdata <= 16'd0;
            cap_write <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == 0) ? ID_VALUE : 16'd0;
            end
        end else begin
            case (state)
                IDLE: begin
                    pready <= 1'b0;
                    perror <= 1'b0;
                    prdata <= 16'd0;
                    if (psel && !penable) begin
                        cap_addr  <= paddr;
                        cap_wdata <= pwdata;
                        cap_write <= pwrite;
                        cnt       <= WS;
                        state     <= ACCESS;
                        if (WAIT_STATES == 0) begin
                            pready <= 1'b1;
                            perror <= setup_err;
                            prdata <= setup_rdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!psel || !penable) begin
                        // Master abandoned the transfer: nothing is committed.
                        state  <= IDLE;
                        pready <= 1'b0;
                        perror <= 1'b0;
                        prdata <= 16'd0;
                    end else if (pready) begin
                        if (cap_write && !cap_err) begin
                            regs[cap_idx] <= cap_wdata;
                        end
                        state  <= IDLE;
                        pready <= 1'b0;
                        perror <= 1'b0;
                        prdata <= 16'd0;
                    end else if (cnt > 4'd1) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        pready <= 1'b1;
                        perror <= cap_err;
                        prdata <= cap_rdata;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
